// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: oversampling UART receive front-end with mid-bit majority vote,
// LSB-first deframing, optional parity and framing/parity error flags.
module uart_rx_sampler #(
    parameter int DataWidth      = 8,
    parameter int OverSampleRate = 16,
    parameter int SyncStages     = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 baud_tick_i,
    input  logic                 rxd_i,
    input  logic                 parity_en_i,
    input  logic                 parity_odd_i,
    output logic                 dv_o,
    output logic [DataWidth-1:0] data_o,
    output logic                 busy_o,
    output logic                 frame_err_o,
    output logic                 parity_err_o
);
    localparam int TW = $clog2(OverSampleRate);
    localparam int BW = $clog2(DataWidth);
    localparam logic [TW-1:0] VoteAt   = TW'(OverSampleRate / 2 + 1);
    localparam logic [TW-1:0] TickLast = TW'(OverSampleRate - 1);
    localparam logic [BW-1:0] BitLast  = BW'(DataWidth - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
    state_t state, state_nx;

    logic [SyncStages-1:0] sync;
    logic                  rxs;
    logic [1:0]            hist;
    logic [TW-1:0]         tcnt;
    logic [BW-1:0]         bcnt;
    logic [DataWidth-1:0]  sr;
    logic                  pbit, pen, podd;
    logic                  vote, resolve;

    assign rxs     = sync[SyncStages-1];
    // hist holds the two previous tick samples; the current rxs is the third
    assign vote    = (hist[1] & hist[0]) | (hist[1] & rxs) | (hist[0] & rxs);
    assign resolve = baud_tick_i && state != IDLE && state != BREAK && tcnt == VoteAt;
    assign busy_o  = state != IDLE;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = (baud_tick_i && !rxs) ? START : IDLE;
            START:   state_nx = resolve ? (vote ? IDLE : DATA) : START;
            DATA:    state_nx = (resolve && bcnt == BitLast) ? (pen ? PARITY : STOP) : DATA;
            PARITY:  state_nx = resolve ? STOP : PARITY;
            STOP:    state_nx = resolve ? (vote ? IDLE : BREAK) : STOP;
            BREAK:   state_nx = (baud_tick_i && rxs) ? IDLE : BREAK;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync         <= '1;
            hist         <= '1;
            tcnt         <= '0;
            bcnt         <= '0;
            sr           <= '0;
            pbit         <= 1'b0;
            pen          <= 1'b0;
            podd         <= 1'b0;
            dv_o         <= 1'b0;
            data_o       <= '0;
            frame_err_o  <= 1'b0;
            parity_err_o <= 1'b0;
        end else begin
            sync <= {sync[SyncStages-2:0], rxd_i};
            dv_o <= resolve && state == STOP;
            if (baud_tick_i) begin
                hist <= {hist[0], rxs};
                tcnt <= (state == IDLE || tcnt == TickLast) ? '0 : tcnt + 1'b1;
                // the last idle tick is the one that leaves IDLE, so this freezes the frame config
                if (state == IDLE) begin
                    pen  <= parity_en_i;
                    podd <= parity_odd_i;
                end
            end
            if (resolve) begin
                if (state == START) bcnt <= '0;
                if (state == DATA) begin
                    sr   <= {vote, sr[DataWidth-1:1]};
                    bcnt <= bcnt + 1'b1;
                end
                if (state == PARITY) pbit <= vote;
                if (state == STOP) begin
                    data_o       <= sr;
                    frame_err_o  <= ~vote;
                    parity_err_o <= pen & (^sr ^ pbit ^ podd);
                end
            end
        end
    end
endmodule
